// File: rtl/fp_operand_loader.sv
// fp_operand_loader: assembles two 32-bit operands (A then B) one byte at a
// time from an 8-bit switch bank, advancing on each press of a load button.
// Optional macro LOADER_DEBOUNCE_EN enables a counter-based button debouncer;
// without it the synchronized button is used directly (fast simulation).

module fp_operand_loader #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        btn,
  output logic [31:0] reg_A,
  output logic [31:0] reg_B,
  output logic [1:0]  byte_idx,
  output logic [1:0]  state,
  output logic        op_valid,
  output logic        op_strobe
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    DONE   = 2'b10
  } state_t;

  logic       r_btnMeta;
  logic       r_btnSync;
  logic [7:0] r_swMeta;
  logic [7:0] r_swSync;
  logic       w_btnLevel;
  logic       r_levelD;
  logic       r_armed;
  logic [1:0] r_warmCount;
  logic       w_press;

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_byteIdx;
  logic [1:0]  w_idxNext;
  logic        w_writeA;
  logic        w_writeB;
  logic        w_strobeNext;
  logic [31:0] r_regA;
  logic [31:0] r_regB;
  logic        r_opStrobe;

  // Two-flop synchronizers bring the raw button and switches into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btnMeta <= 1'b0;
      r_btnSync <= 1'b0;
      r_swMeta  <= 8'd0;
      r_swSync  <= 8'd0;
    end else begin
      r_btnMeta <= btn;
      r_btnSync <= r_btnMeta;
      r_swMeta  <= sw;
      r_swSync  <= r_swMeta;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  logic [15:0] r_dbCount;
  logic        r_btnLevel;

  // Level only flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dbCount  <= 16'd0;
      r_btnLevel <= 1'b0;
    end else if (r_btnSync == r_btnLevel) begin
      r_dbCount <= 16'd0;
    end else if (r_dbCount == DEBOUNCE_CYCLES - 16'd1) begin
      r_btnLevel <= ~r_btnLevel;
      r_dbCount  <= 16'd0;
    end else begin
      r_dbCount <= r_dbCount + 16'd1;
    end
  end

  assign w_btnLevel = r_btnLevel;
`else
  assign w_btnLevel = r_btnSync;
`endif

  // Edge detect plus an arming flag: presses count only once the button has
  // been seen released after reset, so a button held through reset is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_levelD    <= 1'b0;
      r_armed     <= 1'b0;
      r_warmCount <= 2'd0;
    end else begin
      r_levelD <= w_btnLevel;
      if (r_warmCount != 2'd2) begin
        r_warmCount <= r_warmCount + 2'd1;
      end
      if ((r_warmCount == 2'd2) && !r_btnSync && !w_btnLevel) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_press = w_btnLevel & ~r_levelD & r_armed;

  // Next-state logic: each press stores a byte and advances the index/state
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_byteIdx;
    w_writeA    = 1'b0;
    w_writeB    = 1'b0;
    case (r_state)
      LOAD_A: begin
        if (w_press) begin
          w_writeA = 1'b1;
          if (r_byteIdx == 2'd3) begin
            w_stateNext = LOAD_B;
            w_idxNext   = 2'd0;
          end else begin
            w_idxNext = r_byteIdx + 2'd1;
          end
        end
      end
      LOAD_B: begin
        if (w_press) begin
          w_writeB = 1'b1;
          if (r_byteIdx == 2'd3) begin
            w_stateNext = DONE;
            w_idxNext   = 2'd0;
          end else begin
            w_idxNext = r_byteIdx + 2'd1;
          end
        end
      end
      DONE: begin
        if (w_press) begin
          w_stateNext = LOAD_A;
          w_idxNext   = 2'd0;
        end
      end
      default: begin
        w_stateNext = LOAD_A;
        w_idxNext   = 2'd0;
      end
    endcase
    w_strobeNext = (w_stateNext == DONE) && (r_state != DONE);
  end

  // State, byte index and the DONE-entry strobe register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= LOAD_A;
      r_byteIdx  <= 2'd0;
      r_opStrobe <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_byteIdx  <= w_idxNext;
      r_opStrobe <= w_strobeNext;
    end
  end

  // Operand A: the selected byte (0 = MSB) is replaced, other bytes kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regA <= 32'd0;
    end else if (w_writeA) begin
      case (r_byteIdx)
        2'd0:    r_regA[31:24] <= r_swSync;
        2'd1:    r_regA[23:16] <= r_swSync;
        2'd2:    r_regA[15:8]  <= r_swSync;
        default: r_regA[7:0]   <= r_swSync;
      endcase
    end
  end

  // Operand B: same byte-wise update as A
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regB <= 32'd0;
    end else if (w_writeB) begin
      case (r_byteIdx)
        2'd0:    r_regB[31:24] <= r_swSync;
        2'd1:    r_regB[23:16] <= r_swSync;
        2'd2:    r_regB[15:8]  <= r_swSync;
        default: r_regB[7:0]   <= r_swSync;
      endcase
    end
  end

  assign reg_A     = r_regA;
  assign reg_B     = r_regB;
  assign byte_idx  = r_byteIdx;
  assign state     = r_state;
  assign op_valid  = (r_state == DONE);
  assign op_strobe = r_opStrobe;

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed testbench for fp_operand_loader; covers both debounce builds.

module tb_fp_operand_loader;

`ifdef LOADER_DEBOUNCE_EN
  localparam int HOLD = 20;
  localparam int GAP  = 20;
  localparam int LONG = 40;
  localparam int LAT  = 11;
`else
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int LONG = 10;
  localparam int LAT  = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  sw  = 8'd0;
  logic        btn = 1'b0;
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic [1:0]  byte_idx;
  logic [1:0]  state;
  logic        op_valid;
  logic        op_strobe;

  int assertCount = 0;
  int failCount   = 0;
  int strobeCount = 0;
  int stateChanges = 0;
  logic [31:0] strobeA = 32'd0;
  logic [31:0] strobeB = 32'd0;
  logic [1:0]  strobeState = 2'd0;
  logic [1:0]  prevState = 2'd0;

  fp_operand_loader #(.DEBOUNCE_CYCLES(16'd8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .reg_A(reg_A), .reg_B(reg_B), .byte_idx(byte_idx), .state(state),
    .op_valid(op_valid), .op_strobe(op_strobe)
  );

  always #5 clk = ~clk;

  // Monitor strobe pulses and state changes away from the active edge
  always @(negedge clk) begin
    if (op_strobe === 1'b1) begin
      strobeCount++;
      strobeA = reg_A;
      strobeB = reg_B;
      strobeState = state;
    end
    if (state !== prevState) stateChanges++;
    prevState = state;
  end

  task automatic pressByte(input logic [7:0] b);
    @(negedge clk);
    sw  = b;
    btn = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    assertCount++; if (reg_A !== 32'd0) begin failCount++; $display("[TB] FAIL reset_regA: got %h expected %h", reg_A, 32'd0); end
    assertCount++; if (reg_B !== 32'd0) begin failCount++; $display("[TB] FAIL reset_regB: got %h expected %h", reg_B, 32'd0); end
    assertCount++; if (state !== 2'b00) begin failCount++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
    assertCount++; if (byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL reset_idx: got %0d expected 0", byte_idx); end
    assertCount++; if (op_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", op_valid); end
    assertCount++; if (op_strobe !== 1'b0) begin failCount++; $display("[TB] FAIL reset_strobe: got %b expected 0", op_strobe); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency();
    int cycles;
    cycles = 0;
    @(negedge clk);
    sw  = 8'h3C;
    btn = 1'b1;
    while (byte_idx === 2'd0 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    assertCount++; if (cycles != LAT) begin failCount++; $display("[TB] FAIL latency: got %0d cycles expected %0d", cycles, LAT); end
    assertCount++; if (reg_A !== 32'h3c000000) begin failCount++; $display("[TB] FAIL latency_regA: got %h expected %h", reg_A, 32'h3c000000); end
    repeat (HOLD) @(negedge clk);
    btn = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic test_load_sequence();
    logic [7:0] seq [8];
    int s0;
    seq = '{8'h2A, 8'hC4, 8'h92, 8'h14, 8'h6A, 8'hC4, 8'h92, 8'h14};
    pulseReset();
    s0 = strobeCount;
    for (int i = 0; i < 8; i++) begin
      pressByte(seq[i]);
      if (i == 0) begin
        assertCount++; if (reg_A !== 32'h2a000000) begin failCount++; $display("[TB] FAIL seq_first_byte: got %h expected %h", reg_A, 32'h2a000000); end
        assertCount++; if (byte_idx !== 2'd1) begin failCount++; $display("[TB] FAIL seq_first_idx: got %0d expected 1", byte_idx); end
      end
      if (i == 3) begin
        assertCount++; if (state !== 2'b01) begin failCount++; $display("[TB] FAIL seq_to_loadB: got %b expected 01", state); end
        assertCount++; if (byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL seq_loadB_idx: got %0d expected 0", byte_idx); end
        assertCount++; if (reg_B !== 32'd0) begin failCount++; $display("[TB] FAIL seq_regB_untouched: got %h expected 0", reg_B); end
      end
    end
    assertCount++; if (reg_A !== 32'h2ac49214) begin failCount++; $display("[TB] FAIL seq_regA: got %h expected %h", reg_A, 32'h2ac49214); end
    assertCount++; if (reg_B !== 32'h6ac49214) begin failCount++; $display("[TB] FAIL seq_regB: got %h expected %h", reg_B, 32'h6ac49214); end
    assertCount++; if (state !== 2'b10) begin failCount++; $display("[TB] FAIL seq_state: got %b expected 10", state); end
    assertCount++; if (op_valid !== 1'b1) begin failCount++; $display("[TB] FAIL seq_valid: got %b expected 1", op_valid); end
    assertCount++; if (byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL seq_idx: got %0d expected 0", byte_idx); end
    assertCount++; if (strobeCount - s0 != 1) begin failCount++; $display("[TB] FAIL seq_strobe_count: got %0d expected 1", strobeCount - s0); end
    assertCount++; if (strobeA !== 32'h2ac49214 || strobeB !== 32'h6ac49214) begin failCount++; $display("[TB] FAIL seq_strobe_regs: got %h/%h expected 2ac49214/6ac49214", strobeA, strobeB); end
    assertCount++; if (strobeState !== 2'b10) begin failCount++; $display("[TB] FAIL seq_strobe_state: got %b expected 10", strobeState); end
  endtask

  task automatic test_midload_reset();
    pulseReset();
    pressByte(8'h11);
    pressByte(8'h22);
    pressByte(8'h33);
    assertCount++; if (reg_A !== 32'h11223300) begin failCount++; $display("[TB] FAIL mid_partial: got %h expected %h", reg_A, 32'h11223300); end
    @(negedge clk);
    rst = 1'b0;
    #2;
    assertCount++; if (reg_A !== 32'd0 || reg_B !== 32'd0) begin failCount++; $display("[TB] FAIL mid_reset_regs: got %h/%h expected 0/0", reg_A, reg_B); end
    assertCount++; if (state !== 2'b00 || byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL mid_reset_ctrl: got state %b idx %0d expected 00/0", state, byte_idx); end
    assertCount++; if (op_valid !== 1'b0 || op_strobe !== 1'b0) begin failCount++; $display("[TB] FAIL mid_reset_flags: got %b%b expected 00", op_valid, op_strobe); end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    pressByte(8'hAA);
    assertCount++; if (reg_A !== 32'haa000000) begin failCount++; $display("[TB] FAIL mid_reload: got %h expected %h", reg_A, 32'haa000000); end
    assertCount++; if (byte_idx !== 2'd1) begin failCount++; $display("[TB] FAIL mid_reload_idx: got %0d expected 1", byte_idx); end
  endtask

  task automatic test_done_reload();
    pulseReset();
    for (int i = 1; i <= 8; i++) pressByte(8'(i));
    assertCount++; if (state !== 2'b10) begin failCount++; $display("[TB] FAIL reload_done: got %b expected 10", state); end
    pressByte(8'h55);
    assertCount++; if (state !== 2'b00 || byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL reload_back: got state %b idx %0d expected 00/0", state, byte_idx); end
    assertCount++; if (reg_A !== 32'h01020304 || reg_B !== 32'h05060708) begin failCount++; $display("[TB] FAIL reload_kept: got %h/%h expected 01020304/05060708", reg_A, reg_B); end
    assertCount++; if (op_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reload_valid: got %b expected 0", op_valid); end
    pressByte(8'hFF);
    assertCount++; if (reg_A !== 32'hff020304) begin failCount++; $display("[TB] FAIL reload_regA: got %h expected %h", reg_A, 32'hff020304); end
    assertCount++; if (reg_B !== 32'h05060708) begin failCount++; $display("[TB] FAIL reload_regB: got %h expected %h", reg_B, 32'h05060708); end
    assertCount++; if (byte_idx !== 2'd1) begin failCount++; $display("[TB] FAIL reload_idx: got %0d expected 1", byte_idx); end
  endtask

  task automatic test_held_button();
    int sc;
    pulseReset();
    for (int i = 0; i < 8; i++) pressByte(8'h10 + 8'(i));
    sc = stateChanges;
    @(negedge clk);
    sw  = 8'h99;
    btn = 1'b1;
    repeat (LONG) @(negedge clk);
    btn = 1'b0;
    repeat (GAP) @(negedge clk);
    assertCount++; if (stateChanges - sc != 1) begin failCount++; $display("[TB] FAIL held_changes: got %0d expected 1", stateChanges - sc); end
    assertCount++; if (state !== 2'b00 || byte_idx !== 2'd0) begin failCount++; $display("[TB] FAIL held_state: got state %b idx %0d expected 00/0", state, byte_idx); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sw = 8'hC0 + 8'(i);
    end
    repeat (4) @(negedge clk);
    assertCount++; if (reg_A !== 32'h10111213 || reg_B !== 32'h14151617) begin failCount++; $display("[TB] FAIL nopress_regs: got %h/%h expected 10111213/14151617", reg_A, reg_B); end
    assertCount++; if (byte_idx !== 2'd0 || state !== 2'b00) begin failCount++; $display("[TB] FAIL nopress_ctrl: got state %b idx %0d expected 00/0", state, byte_idx); end
  endtask

  task automatic test_reset_held_button();
    @(negedge clk);
    btn = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LONG) @(negedge clk);
    assertCount++; if (byte_idx !== 2'd0 || reg_A !== 32'd0) begin failCount++; $display("[TB] FAIL heldrst_nopress: got idx %0d regA %h expected 0/0", byte_idx, reg_A); end
    btn = 1'b0;
    repeat (GAP) @(negedge clk);
    pressByte(8'h5A);
    assertCount++; if (reg_A !== 32'h5a000000) begin failCount++; $display("[TB] FAIL heldrst_repress: got %h expected %h", reg_A, 32'h5a000000); end
    assertCount++; if (byte_idx !== 2'd1) begin failCount++; $display("[TB] FAIL heldrst_idx: got %0d expected 1", byte_idx); end
  endtask

`ifdef LOADER_DEBOUNCE_EN
  task automatic test_glitch();
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sw  = 8'h77;
      btn = 1'b1;
      repeat (5) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
    end
    assertCount++; if (byte_idx !== 2'd0 || reg_A !== 32'd0) begin failCount++; $display("[TB] FAIL glitch_ignored: got idx %0d regA %h expected 0/0", byte_idx, reg_A); end
    pressByte(8'h77);
    assertCount++; if (reg_A !== 32'h77000000 || byte_idx !== 2'd1) begin failCount++; $display("[TB] FAIL glitch_hold_once: got regA %h idx %0d expected 77000000/1", reg_A, byte_idx); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_load_sequence();
    test_midload_reset();
    test_done_reload();
    test_held_button();
    test_reset_held_button();
`ifdef LOADER_DEBOUNCE_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
